tff_bank_sched: RTL and testbench
=================================

// Module: tff_bank_sched
// PURPOSE
//  Sequencer and round-robin arbiter for a bank of WIDTH T flip-flops shared by two requesters.
//  Each requester issues one command: TOGGLE, CLEAR, LOAD or NOP.
//  The block turns every command into a toggle mask, so the bank only ever sees t/en.
//  It drives en for exactly one cycle, waits a settle window, then reports completion.
// PARAMETERS
//  WIDTH          8  number of T flip-flops in the bank (q width)
//  SETTLE_CYCLES  1  idle cycles after the en pulse, before done (0 = no settle state)
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  reset       in   1      synchronous, active-high; clears all state
//  req0_valid  in   1      requester 0 has a command; held until accepted
//  req0_cmd    in   2      00 NOP, 01 TOGGLE, 10 CLEAR, 11 LOAD
//  req0_data   in   WIDTH  toggle mask (TOGGLE) or target value (LOAD); ignored otherwise
//  req0_ready  out  1      combinational; transfer = valid & ready on a clk edge
//  req1_valid/req1_cmd/req1_data/req1_ready   same as req0_*, for requester 1
//  q           out  WIDTH  bank state
//  busy        out  1      1 whenever state != IDLE
//  done        out  1      one-cycle pulse when a command completes
//  done_id     out  1      requester that owns the completing command; valid while done=1
//  op_count    out  16     count of completed non-NOP commands; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset values: q=0, busy=0, done=0, done_id=0, op_count=0, state=IDLE, RR priority=req0.
//  FSM: IDLE -> ISSUE -> SETTLE (SETTLE_CYCLES cycles; skipped if 0) -> DONE -> IDLE.
//  IDLE:
//   - reqN_ready=1 only for the arbitration winner, and only while its valid=1.
//   - Winner is the single valid requester; if both are valid, the priority holder wins.
//   - On transfer: capture cmd/data/id, go to ISSUE.
//   - Priority passes to the other requester after every grant.
//  ISSUE (one cycle): en=1, t=mask, where
//   - mask = 0 for NOP, data for TOGGLE, q for CLEAR, q^data for LOAD.
//   - mask uses q as it is in the ISSUE cycle; the bank updates q <= q ^ mask at the end of ISSUE.
//  SETTLE: en=0; an internal counter runs SETTLE_CYCLES cycles.
//  DONE (one cycle):
//   - done=1, done_id=captured id.
//   - op_count increments unless the captured cmd was NOP.
//   - Next state is IDLE.
//  Latency: transfer on edge E0 -> q valid after E1 -> done high in cycle 2+SETTLE_CYCLES after E0.
//  Throughput: one command per 3+SETTLE_CYCLES cycles.
//  Ready outside IDLE: both ready=0; requesters keep valid high and wait.
//  Reset mid-operation: q=0 and FSM=IDLE on the next edge; the captured command is dropped; no done pulse.
//  en is never asserted outside ISSUE. q changes only in the cycle after ISSUE, or on reset.
// STRUCTURE
//  Package tff_sched_pkg:
//   - cmd localparams CMD_NOP/CMD_TOGGLE/CMD_CLEAR/CMD_LOAD;
//   - state encodings ST_IDLE/ST_ISSUE/ST_SETTLE/ST_DONE.
//  Sub-module tff_bit (clk, reset, t, en, q): sync reset, toggles when en&t.
//   - Instantiated WIDTH times via generate to form the bank.
//  Top level holds: FSM, RR pointer, capture registers, mask logic, settle counter, op_count.
// TESTING (WIDTH=8, SETTLE_CYCLES=1)
//  1 Reset:
//    - reset=1 for 2 cycles, no valid -> q=0x00, busy=0, done=0, both ready=0, op_count=0.
//  2 Single toggle:
//    - req0 TOGGLE 0xA5 -> ready0=1 in accept cycle; q=0xA5 one edge after ISSUE.
//    - done=1, done_id=0 three cycles after accept; op_count=1.
//  3 Load:
//    - from q=0xA5, req1 LOAD 0x3C -> ISSUE mask=0x99; q=0x3C; done_id=1; op_count=2.
//  4 Contention:
//    - after reset, req0 TOGGLE 0x01 and req1 TOGGLE 0x80 raised in the same cycle.
//    - req0 is granted first, req1 next; done_id sequence 0 then 1; q=0x81.
//    - A third simultaneous request is granted to req0.
//  5 Clear and NOP:
//    - from q=0x81, CLEAR -> q=0x00, op_count+1.
//    - NOP -> q unchanged, done still pulses, op_count unchanged.
//  6 Reset mid-op:
//    - reset=1 during the SETTLE cycle after TOGGLE 0xFF -> next cycle q=0x00, busy=0.
//    - No done pulse; the next grant goes to req0.

Source files
------------

// File: rtl/tff_sched_pkg.sv
// Shared command codes and FSM state type for the T flip-flop bank scheduler.
package tff_sched_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_NOP    = 2'b00;
  localparam cmd_t CMD_TOGGLE = 2'b01;
  localparam cmd_t CMD_CLEAR  = 2'b10;
  localparam cmd_t CMD_LOAD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tff_bank_sched_if.sv
// Two-requester command handshake into the bank scheduler.
interface tff_bank_sched_if
  import tff_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             req0_valid;
  cmd_t             req0_cmd;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;

  logic             req1_valid;
  cmd_t             req1_cmd;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_cmd, req0_data,
    output req1_valid, req1_cmd, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_data,
    input  req1_valid, req1_cmd, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/tff_bit.sv
// Single T flip-flop with synchronous reset; toggles when both en and t are high.
module tff_bit (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic en,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (en && t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff_bank_sched.sv
// Round-robin sequencer driving a bank of T flip-flops; every command becomes a toggle mask.
module tff_bank_sched
  import tff_sched_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  tff_bank_sched_if.slave  bus,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [15:0]      op_count
);

  localparam int unsigned CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;        // 0: req0 holds priority, 1: req1 holds priority
  cmd_t             r_cmd;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [15:0]      r_op_count;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_en;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_q;

  always_comb begin
    w_grant0       = bus.req0_valid & (~bus.req1_valid | ~r_prio);
    w_grant1       = bus.req1_valid & (~bus.req0_valid |  r_prio);
    bus.req0_ready = (r_state == ST_IDLE) & w_grant0;
    bus.req1_ready = (r_state == ST_IDLE) & w_grant1;
    w_accept       = (r_state == ST_IDLE) & (w_grant0 | w_grant1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE:  w_state_nxt = (SETTLE_CYCLES == 0) ? ST_DONE : ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == CNT_W'(SETTLE_LAST)) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prio       <= 1'b0;
      r_cmd        <= CMD_NOP;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_settle_cnt <= '0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd  <= w_grant0 ? bus.req0_cmd  : bus.req1_cmd;
        r_data <= w_grant0 ? bus.req0_data : bus.req1_data;
        r_id   <= w_grant1;
        r_prio <= w_grant0;
      end
      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
      end else begin
        r_settle_cnt <= '0;
      end
      if ((r_state == ST_DONE) && (r_cmd != CMD_NOP)) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  // CLEAR and LOAD are expressed relative to the live bank value so the bank only toggles.
  always_comb begin
    w_mask = '0;
    case (r_cmd)
      CMD_NOP:    w_mask = '0;
      CMD_TOGGLE: w_mask = r_data;
      CMD_CLEAR:  w_mask = w_q;
      CMD_LOAD:   w_mask = w_q ^ r_data;
      default:    w_mask = '0;
    endcase
  end

  assign w_en = (r_state == ST_ISSUE);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
    tff_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .t     (w_mask[gi]),
      .en    (w_en),
      .q     (w_q[gi])
    );
  end

  assign q        = w_q;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign done_id  = (r_state == ST_DONE) & r_id;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_tff_bank_sched.sv
// Bench for tff_bank_sched: directed scenarios plus randomized commands against a transaction model.
module tb_tff_bank_sched;
  import tff_sched_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 1;

  logic          clk;
  logic          reset;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [15:0]   op_count;

  tff_bank_sched_if #(.WIDTH(W)) bus ();

  tff_bank_sched #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Model: bank value, priority holder, completed-op count, and per-requester pending command.
  logic [W-1:0] m_q;
  int           m_prio;
  logic [15:0]  m_ops;
  logic         p_v [2];
  logic [1:0]   p_c [2];
  logic [W-1:0] p_d [2];
  int           last_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req0_valid = p_v[0];
    bus.req0_cmd   = p_c[0];
    bus.req0_data  = p_d[0];
    bus.req1_valid = p_v[1];
    bus.req1_cmd   = p_c[1];
    bus.req1_data  = p_d[1];
  endtask

  task automatic model_reset();
    m_q    = '0;
    m_prio = 0;
    m_ops  = '0;
  endtask

  task automatic do_reset(input int unsigned cycles);
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    drive();
    reset = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) step();
    reset = 1'b0;
    model_reset();
  endtask

  // One arbitration attempt from IDLE, followed through to completion if anything is granted.
  task automatic run_one();
    int           w;
    logic [W-1:0] nq;
    logic [15:0]  ops_before;
    drive();
    #1;
    w = -1;
    if (p_v[0] && p_v[1]) w = m_prio;
    else if (p_v[0])      w = 0;
    else if (p_v[1])      w = 1;
    last_w = w;
    chk("idle_ready0", {31'd0, bus.req0_ready}, {31'd0, (w == 0)});
    chk("idle_ready1", {31'd0, bus.req1_ready}, {31'd0, (w == 1)});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    if (w < 0) begin
      step();
      return;
    end
    case (p_c[w])
      2'd0:    nq = m_q;
      2'd1:    nq = m_q ^ p_d[w];
      2'd2:    nq = '0;
      default: nq = p_d[w];
    endcase
    ops_before = m_ops;
    if (p_c[w] != 2'd0) m_ops = m_ops + 16'd1;
    m_prio = 1 - w;
    step();
    p_v[w] = 1'b0;
    drive();
    #1;
    chk("issue_busy", {31'd0, busy}, 32'd1);
    chk("issue_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("issue_q_hold", {24'd0, q}, {24'd0, m_q});
    chk("issue_done", {31'd0, done}, 32'd0);
    step();
    m_q = nq;
    chk("q_after_issue", {24'd0, q}, {24'd0, m_q});
    for (int unsigned i = 0; i < SC; i++) begin
      chk("settle_done", {31'd0, done}, 32'd0);
      chk("settle_busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_id", {31'd0, done_id}, w);
    chk("done_opcnt", {16'd0, op_count}, {16'd0, ops_before});
    step();
    chk("post_done", {31'd0, done}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("op_count", {16'd0, op_count}, {16'd0, m_ops});
    chk("post_q", {24'd0, q}, {24'd0, m_q});
  endtask

  task automatic set_req(input int r, input logic [1:0] c, input logic [W-1:0] d);
    p_v[r] = 1'b1;
    p_c[r] = c;
    p_d[r] = d;
  endtask

  initial begin
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      p_v[r] = 1'b0; p_c[r] = 2'd0; p_d[r] = '0;
    end
    drive();
    model_reset();
    last_w = -1;

    // Reset state
    do_reset(2);
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_id", {31'd0, done_id}, 32'd0);
    chk("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("rst_opcnt", {16'd0, op_count}, 32'd0);

    // Single toggle, then load
    set_req(0, CMD_TOGGLE, 8'hA5);
    run_one();
    chk("t2_q", {24'd0, q}, 32'hA5);
    chk("t2_ops", {16'd0, op_count}, 32'd1);
    set_req(1, CMD_LOAD, 8'h3C);
    run_one();
    chk("t3_q", {24'd0, q}, 32'h3C);
    chk("t3_id", last_w, 32'd1);
    chk("t3_ops", {16'd0, op_count}, 32'd2);

    // Contention, then clear and NOP as a third simultaneous pair
    do_reset(1);
    set_req(0, CMD_TOGGLE, 8'h01);
    set_req(1, CMD_TOGGLE, 8'h80);
    run_one();
    chk("t4_first", last_w, 32'd0);
    run_one();
    chk("t4_second", last_w, 32'd1);
    chk("t4_q", {24'd0, q}, 32'h81);
    set_req(0, CMD_CLEAR, 8'h5A);
    set_req(1, CMD_NOP, 8'hFF);
    run_one();
    chk("t4_third", last_w, 32'd0);
    chk("t5_clear_q", {24'd0, q}, 32'h00);
    chk("t5_clear_ops", {16'd0, op_count}, 32'd3);
    run_one();
    chk("t5_nop_q", {24'd0, q}, 32'h00);
    chk("t5_nop_ops", {16'd0, op_count}, 32'd3);

    // Reset during SETTLE drops the command
    set_req(0, CMD_TOGGLE, 8'hFF);
    drive();
    step();
    p_v[0] = 1'b0;
    drive();
    step();
    chk("t6_q_pre", {24'd0, q}, 32'hFF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("t6_q", {24'd0, q}, 32'h00);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_done", {31'd0, done}, 32'd0);
    end
    set_req(0, CMD_LOAD, 8'h12);
    set_req(1, CMD_LOAD, 8'h34);
    run_one();
    chk("t6_grant", last_w, 32'd0);
    run_one();

    // Randomized traffic; a losing requester keeps its command pending
    for (int n = 0; n < 300; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r] && ($urandom_range(0, 3) != 0)) begin
          set_req(r, 2'($urandom_range(0, 3)), 8'($urandom));
        end
      end
      run_one();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
